// File: rtl/step_updown_counter16_pkg.sv
// Shared constants and types for the step up/down counter slice.
package step_updown_counter16_pkg;

  // Count direction encodings
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Default geometry of the counter
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STEP_W = 3;

  // Which action the register bank takes on a given edge
  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_COUNT = 2'd2
  } counter_op_e;

  // Resolve the CLEAR > LOAD > count priority into a single action
  function automatic counter_op_e select_op(input logic clear, input logic load);
    if (clear) begin
      return OP_CLEAR;
    end
    if (load) begin
      return OP_LOAD;
    end
    return OP_COUNT;
  endfunction

endpackage

// File: rtl/step_updown_counter16_if.sv
// Load/step control inputs and count/wrap outputs of the counter, bundled.
interface step_updown_counter16_if
  import step_updown_counter16_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
);

  logic [WIDTH-1:0]  X;
  logic              LOAD;
  logic              direction;
  logic [STEP_W-1:0] value;
  logic [WIDTH-1:0]  out;
  logic              wrap;

  // Side that controls the counter (sequencer or bench)
  modport master (
    output X, LOAD, direction, value,
    input  out, wrap
  );

  // The counter itself
  modport slave (
    input  X, LOAD, direction, value,
    output out, wrap
  );

endinterface

// File: rtl/step_updown_counter16_step_addsub.sv
// Combinational add/subtract of a zero-extended step magnitude, with carry/borrow.
module step_addsub
  import step_updown_counter16_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic [WIDTH-1:0]  cur,
  input  logic [STEP_W-1:0] step,
  input  logic              dir,
  output logic [WIDTH-1:0]  next,
  output logic              carry
);

  logic [WIDTH-1:0] step_ext;
  logic [WIDTH:0]   result;

  assign step_ext = {{(WIDTH-STEP_W){1'b0}}, step};

  // One extra bit holds the carry on add, or goes high on borrow when step exceeds cur
  always_comb begin
    result = '0;
    if (dir == DIR_UP) begin
      result = {1'b0, cur} + {1'b0, step_ext};
    end else begin
      result = {1'b0, cur} - {1'b0, step_ext};
    end
  end

  assign next  = result[WIDTH-1:0];
  assign carry = result[WIDTH];

endmodule

// File: rtl/step_updown_counter16.sv
// 16-bit up/down counter with parallel load, per-cycle step 0..7 and a registered wrap flag.
module step_updown_counter16
  import step_updown_counter16_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic                    CLK,
  input  logic                    CLEAR,
  step_updown_counter16_if.slave  bus
);

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic [WIDTH-1:0] count_next;
  logic             step_carry;
  logic [WIDTH-1:0] count_d;
  logic             wrap_d;
  counter_op_e      op;

  step_addsub #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_addsub (
    .cur   (count_q),
    .step  (bus.value),
    .dir   (bus.direction),
    .next  (count_next),
    .carry (step_carry)
  );

  assign op = select_op(CLEAR, bus.LOAD);

  // Pick the next count and wrap value according to the edge's action
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    case (op)
      OP_CLEAR: begin
        count_d = '0;
        wrap_d  = 1'b0;
      end
      OP_LOAD: begin
        count_d = bus.X;
        wrap_d  = 1'b0;
      end
      default: begin
        count_d = count_next;
        wrap_d  = step_carry;
      end
    endcase
  end

  // Count and wrap registers; CLEAR is synchronous
  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.out  = count_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_step_updown_counter16.sv
// Directed bench for step_updown_counter16 with a queue-based scoreboard.
module tb_step_updown_counter16;
  import step_updown_counter16_pkg::*;

  typedef struct {
    string       name;
    logic [15:0] out;
    logic        wrap;
  } exp_t;

  logic CLK;
  logic CLEAR;
  int   errors;
  int   checks;
  exp_t sb_q[$];

  step_updown_counter16_if #(.WIDTH(16), .STEP_W(3)) bus ();

  step_updown_counter16 #(.WIDTH(16), .STEP_W(3)) dut (
    .CLK   (CLK),
    .CLEAR (CLEAR),
    .bus   (bus)
  );

  // Free-running 10 ns clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Compare one DUT response against its queued expectation
  task automatic check_output(input exp_t e, input logic [15:0] act_out, input logic act_wrap);
    checks++;
    if (act_out !== e.out) begin
      errors++;
      $display("[TB] FAIL %s out: got 0x%04h expected 0x%04h", e.name, act_out, e.out);
    end
    checks++;
    if (act_wrap !== e.wrap) begin
      errors++;
      $display("[TB] FAIL %s wrap: got %b expected %b", e.name, act_wrap, e.wrap);
    end
  endtask

  // Drive one edge's inputs at the falling edge and queue the expected result
  task automatic apply_stimulus(input string name, input logic clr, input logic ld,
                                input logic [15:0] x, input logic dir, input logic [2:0] val,
                                input logic [15:0] exp_out, input logic exp_wrap);
    exp_t e;
    @(negedge CLK);
    CLEAR         = clr;
    bus.LOAD      = ld;
    bus.X         = x;
    bus.direction = dir;
    bus.value     = val;
    e.name = name;
    e.out  = exp_out;
    e.wrap = exp_wrap;
    sb_q.push_back(e);
  endtask

  // Monitor: registered outputs are valid shortly after each rising edge
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_output(e, bus.out, bus.wrap);
    end
  end

  // Directed sequence
  initial begin
    errors        = 0;
    checks        = 0;
    CLEAR         = 1'b0;
    bus.LOAD      = 1'b0;
    bus.X         = 16'h0000;
    bus.direction = DIR_UP;
    bus.value     = 3'd0;
    repeat (2) @(posedge CLK);

    apply_stimulus("clear_over_load0", 1, 1, 16'h1234, DIR_UP,   3'd5, 16'h0000, 0);
    apply_stimulus("clear_over_load1", 1, 1, 16'h1234, DIR_DOWN, 3'd7, 16'h0000, 0);

    apply_stimulus("load16",           0, 1, 16'h0010, DIR_DOWN, 3'd2, 16'h0010, 0);
    apply_stimulus("down2_a",          0, 0, 16'hAAAA, DIR_DOWN, 3'd2, 16'h000E, 0);
    apply_stimulus("down2_b",          0, 0, 16'hAAAA, DIR_DOWN, 3'd2, 16'h000C, 0);
    apply_stimulus("down2_c",          0, 0, 16'hAAAA, DIR_DOWN, 3'd2, 16'h000A, 0);
    apply_stimulus("down2_d",          0, 0, 16'hAAAA, DIR_DOWN, 3'd2, 16'h0008, 0);

    apply_stimulus("load_fffe",        0, 1, 16'hFFFE, DIR_UP,   3'd3, 16'hFFFE, 0);
    apply_stimulus("up3_carry",        0, 0, 16'h0000, DIR_UP,   3'd3, 16'h0001, 1);
    apply_stimulus("up3_after",        0, 0, 16'h0000, DIR_UP,   3'd3, 16'h0004, 0);

    apply_stimulus("load_0001",        0, 1, 16'h0001, DIR_DOWN, 3'd2, 16'h0001, 0);
    apply_stimulus("down2_borrow",     0, 0, 16'h0000, DIR_DOWN, 3'd2, 16'hFFFF, 1);

    apply_stimulus("load_0100",        0, 1, 16'h0100, DIR_UP,   3'd0, 16'h0100, 0);
    apply_stimulus("hold_up",          0, 0, 16'h0000, DIR_UP,   3'd0, 16'h0100, 0);
    apply_stimulus("hold_down",        0, 0, 16'h0000, DIR_DOWN, 3'd0, 16'h0100, 0);
    apply_stimulus("hold_up2",         0, 0, 16'h0000, DIR_UP,   3'd0, 16'h0100, 0);

    apply_stimulus("load_0007",        0, 1, 16'h0007, DIR_DOWN, 3'd7, 16'h0007, 0);
    apply_stimulus("down7_to_zero",    0, 0, 16'h0000, DIR_DOWN, 3'd7, 16'h0000, 0);

    apply_stimulus("load_ffff",        0, 1, 16'hFFFF, DIR_UP,   3'd7, 16'hFFFF, 0);
    apply_stimulus("up7_carry",        0, 0, 16'h0000, DIR_UP,   3'd7, 16'h0006, 1);
    apply_stimulus("down3_mixed",      0, 0, 16'h0000, DIR_DOWN, 3'd3, 16'h0003, 0);
    apply_stimulus("up5_mixed",        0, 0, 16'h0000, DIR_UP,   3'd5, 16'h0008, 0);

    apply_stimulus("load_0005",        0, 1, 16'h0005, DIR_UP,   3'd1, 16'h0005, 0);
    apply_stimulus("up1_a",            0, 0, 16'h0000, DIR_UP,   3'd1, 16'h0006, 0);
    apply_stimulus("up1_b",            0, 0, 16'h0000, DIR_UP,   3'd1, 16'h0007, 0);
    apply_stimulus("clear_mid",        1, 0, 16'h0000, DIR_UP,   3'd1, 16'h0000, 0);
    apply_stimulus("resume_from_zero", 0, 0, 16'h0000, DIR_UP,   3'd1, 16'h0001, 0);

    apply_stimulus("load_ffff_b",      0, 1, 16'hFFFF, DIR_UP,   3'd1, 16'hFFFF, 0);
    apply_stimulus("up1_carry",        0, 0, 16'h0000, DIR_UP,   3'd1, 16'h0000, 1);
    apply_stimulus("clear_after_wrap", 1, 1, 16'h5555, DIR_UP,   3'd1, 16'h0000, 0);

    @(negedge CLK);
    CLEAR    = 1'b0;
    bus.LOAD = 1'b0;
    bus.value = 3'd0;
    repeat (3) @(negedge CLK);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
